// File: rtl/addr_sequencer_if.sv
// Burst request / address-strobe bundle between a requester and the
// address sequencer. The requester owns the request fields and the
// downstream stall; the sequencer owns the handshake reply and the
// decoder-facing address strobe and status pulses.
interface addr_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_start;
   logic [4:0] req_len;
   logic       req_dir;
   logic       stall;
   logic       enable;
   logic [3:0] addr;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output req_valid, req_start, req_len, req_dir, stall,
      input  req_ready, enable, addr, busy, done, err
   );

   modport slave (
      input  req_valid, req_start, req_len, req_dir, stall,
      output req_ready, enable, addr, busy, done, err
   );
endinterface

// File: rtl/addr_sequencer.sv
// Address burst sequencer feeding a 4-to-16 decoder. A request names a
// start address, a length and a direction; the block then walks the
// address up or down (wrapping modulo 16), raising enable for exactly
// req_len un-stalled cycles, and finishes with a one-cycle done pulse.
// Requests of length 0 or longer than BURST_MAX are rejected with a
// one-cycle err pulse and never leave IDLE.
module addr_sequencer #(
   parameter int BURST_MAX = 16
) (
   input logic             clk,
   input logic             rst,
   addr_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state;
   state_t     next_state;
   logic [3:0] addr_q;
   logic [4:0] remaining;
   logic       dir_q;
   logic       err_q;
   logic       accept;
   logic       legal;
   logic       step;

   // Handshake only happens in IDLE, so req_valid elsewhere is ignored.
   assign accept = bus.req_valid && (state == IDLE);
   assign legal  = (bus.req_len != 5'd0) && (bus.req_len <= 5'(BURST_MAX));
   // An address is issued (and the burst advances) on every un-stalled RUN cycle.
   assign step   = (state == RUN) && !bus.stall;

   // State register; reset discards any burst in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and decoder-facing outputs, all derived from the state.
   always_comb begin
      next_state    = state;
      bus.req_ready = 1'b0;
      bus.enable    = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.addr      = addr_q;
      bus.err       = err_q;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (accept && legal) begin
               next_state = RUN;
            end
         end
         RUN: begin
            bus.busy   = 1'b1;
            bus.enable = !bus.stall;
            if (step && (remaining == 5'd1)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            bus.done   = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Burst datapath: load on legal acceptance, step and count down when
   // not stalled, and flag a rejected request for exactly one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= 4'd0;
         remaining <= 5'd0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         err_q <= accept && !legal;
         if (accept && legal) begin
            addr_q    <= bus.req_start;
            remaining <= bus.req_len;
            dir_q     <= bus.req_dir;
         end else if (step) begin
            addr_q    <= dir_q ? (addr_q - 4'd1) : (addr_q + 4'd1);
            remaining <= remaining - 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed bench for addr_sequencer: wrap in both directions, stall,
// illegal lengths, reset mid-burst and a full 16-address sweep with
// req_valid held high. Inputs change on the falling edge and outputs
// are sampled 1 ns later, well away from the rising edge.
module tb_addr_sequencer;

   logic clk;
   logic rst;
   int   check_count;
   int   pass_count;

   addr_sequencer_if seq_if ();

   addr_sequencer #(.BURST_MAX(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (seq_if.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever stops advancing.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      check_count++;
      if (observed == expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drive the request fields for the next rising edge.
   task automatic applyStimulus(input logic valid, input logic [3:0] start,
                                input logic [4:0] len, input logic dir);
      seq_if.req_valid = valid;
      seq_if.req_start = start;
      seq_if.req_len   = len;
      seq_if.req_dir   = dir;
   endtask

   // One clock of a burst: set valid/stall, then check the visible outputs.
   task automatic runCycle(input string tag, input logic valid_in, input logic stall_in,
                           input logic exp_en, input logic [3:0] exp_addr,
                           input logic exp_busy, input logic exp_done);
      @(negedge clk);
      seq_if.req_valid = valid_in;
      seq_if.stall     = stall_in;
      #1;
      checkOutput({tag, ".enable"}, int'(seq_if.enable), int'(exp_en));
      checkOutput({tag, ".addr"},   int'(seq_if.addr),   int'(exp_addr));
      checkOutput({tag, ".busy"},   int'(seq_if.busy),   int'(exp_busy));
      checkOutput({tag, ".done"},   int'(seq_if.done),   int'(exp_done));
      checkOutput({tag, ".ready"},  int'(seq_if.req_ready), int'(!(exp_busy || exp_done)));
      checkOutput({tag, ".err"},    int'(seq_if.err),    0);
   endtask

   // Present a request on the coming rising edge.
   task automatic issueRequest(input logic [3:0] start, input logic [4:0] len, input logic dir);
      @(negedge clk);
      seq_if.stall = 1'b0;
      applyStimulus(1'b1, start, len, dir);
   endtask

   // Present an illegal length and expect a single err pulse with no burst.
   task automatic illegalRequest(input string tag, input logic [4:0] len);
      issueRequest(4'd3, len, 1'b0);
      #1;
      checkOutput({tag, ".ready_before"}, int'(seq_if.req_ready), 1);
      @(negedge clk);
      seq_if.req_valid = 1'b0;
      #1;
      checkOutput({tag, ".err_pulse"}, int'(seq_if.err), 1);
      checkOutput({tag, ".enable"},    int'(seq_if.enable), 0);
      checkOutput({tag, ".busy"},      int'(seq_if.busy), 0);
      checkOutput({tag, ".ready"},     int'(seq_if.req_ready), 1);
      @(negedge clk);
      #1;
      checkOutput({tag, ".err_clear"}, int'(seq_if.err), 0);
      checkOutput({tag, ".enable2"},   int'(seq_if.enable), 0);
   endtask

   initial begin
      logic [3:0] sweep_addr;
      check_count = 0;
      pass_count  = 0;
      rst = 1'b1;
      seq_if.stall = 1'b0;
      applyStimulus(1'b0, 4'd0, 5'd0, 1'b0);

      // Reset state.
      @(negedge clk);
      #1;
      checkOutput("rst.enable", int'(seq_if.enable), 0);
      checkOutput("rst.busy",   int'(seq_if.busy), 0);
      checkOutput("rst.done",   int'(seq_if.done), 0);
      checkOutput("rst.err",    int'(seq_if.err), 0);
      checkOutput("rst.addr",   int'(seq_if.addr), 0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("post_rst.ready", int'(seq_if.req_ready), 1);

      // Increment wrap: 14,15,0,1 then done; addr rests at 2.
      issueRequest(4'd14, 5'd4, 1'b0);
      runCycle("inc0", 1'b0, 1'b0, 1'b1, 4'd14, 1'b1, 1'b0);
      runCycle("inc1", 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
      runCycle("inc2", 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0);
      runCycle("inc3", 1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0);
      runCycle("inc_done", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1);
      runCycle("inc_idle", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);

      // Decrement wrap: 1,0,15 then done; addr rests at 14.
      issueRequest(4'd1, 5'd3, 1'b1);
      runCycle("dec0", 1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0);
      runCycle("dec1", 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0);
      runCycle("dec2", 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
      runCycle("dec_done", 1'b0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b1);
      runCycle("dec_idle", 1'b0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b0);

      // Stall on the 2nd and 3rd RUN cycles: enable 1,0,0,1,1; addr 5,6,6,6,7.
      issueRequest(4'd5, 5'd3, 1'b0);
      runCycle("stl0", 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
      runCycle("stl1", 1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
      runCycle("stl2", 1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
      runCycle("stl3", 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
      runCycle("stl4", 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
      runCycle("stl_done", 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1);

      // Illegal lengths at both ends of the legal range.
      illegalRequest("len0",  5'd0);
      illegalRequest("len17", 5'd17);

      // Reset in the 5th RUN cycle of a 16-long burst.
      issueRequest(4'd0, 5'd16, 1'b0);
      for (int i = 0; i < 4; i++) begin
         runCycle($sformatf("rstb%0d", i), 1'b0, 1'b0, 1'b1, 4'(i), 1'b1, 1'b0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst.enable", int'(seq_if.enable), 0);
      checkOutput("midrst.addr",   int'(seq_if.addr), 0);
      checkOutput("midrst.busy",   int'(seq_if.busy), 0);
      checkOutput("midrst.done",   int'(seq_if.done), 0);
      checkOutput("midrst.err",    int'(seq_if.err), 0);
      @(negedge clk);
      rst = 1'b0;
      runCycle("after_rst", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      issueRequest(4'd9, 5'd1, 1'b0);
      runCycle("single0", 1'b0, 1'b0, 1'b1, 4'd9,  1'b1, 1'b0);
      runCycle("single_done", 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b1);
      runCycle("single_idle", 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);

      // Full sweep with req_valid held high; the repeat request only lands after DONE.
      issueRequest(4'd0, 5'd16, 1'b0);
      for (int i = 0; i < 16; i++) begin
         runCycle($sformatf("sweep%0d", i), 1'b1, 1'b0, 1'b1, 4'(i), 1'b1, 1'b0);
      end
      runCycle("sweep_done", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      runCycle("sweep_idle", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      sweep_addr = 4'd0;
      for (int i = 0; i < 16; i++) begin
         runCycle($sformatf("sweep2_%0d", i), 1'b0, 1'b0, 1'b1, sweep_addr, 1'b1, 1'b0);
         sweep_addr = sweep_addr + 4'd1;
      end
      runCycle("sweep2_done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 Parameter: BURST_MAX, default 16, largest accepted burst length (legal range 1..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 req_valid  input  1  burst request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_start  input  4  first address of the burst.
REQ-008 req_len  input  5  number of addresses to issue.
REQ-009 req_dir  input  1  step direction: 0 = increment, 1 = decrement.
REQ-010 stall  input  1  downstream hold request.
REQ-011 enable  output  1  address-valid strobe; drives the 4-to-16 decoder enable.
REQ-012 addr  output  4  current address; drives the decoder address input.
REQ-013 busy  output  1  burst in progress.
REQ-014 done  output  1  one-cycle burst-complete pulse.
REQ-015 err  output  1  one-cycle illegal-request pulse.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 A request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-019 Legal acceptance (1 <= req_len <= BURST_MAX) SHALL capture req_start into the address register, req_len into a remaining counter and req_dir, then go IDLE->RUN.
REQ-020 Illegal acceptance (req_len=0 or req_len>BURST_MAX) SHALL set err=1 for the next cycle only.
REQ-021 An illegal acceptance SHALL leave the FSM in IDLE with no enable issued.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 enable SHALL be combinational: 1 when state=RUN and stall=0, otherwise 0.
REQ-024 addr SHALL be the address register in every state; it holds its last value in IDLE and DONE.
REQ-025 Latency: the first enable is asserted in the cycle immediately after the acceptance edge, when stall=0.
REQ-026 On each RUN edge with stall=0, addr SHALL step by +1 or -1 modulo 16 and the remaining count SHALL decrement by 1.
REQ-027 Address wrap is mandatory in both directions: 15+1 -> 0 and 0-1 -> 15.
REQ-028 On a RUN edge with stall=1, addr and the remaining count SHALL hold; a stall has no length limit.
REQ-029 A RUN edge with stall=0 and remaining=1 SHALL go to DONE; addr still steps on that edge.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-031 Exactly req_len enable cycles SHALL occur per legal burst, regardless of stall pattern.
REQ-032 req_valid outside IDLE SHALL be ignored; back-to-back bursts are separated by at least the DONE cycle.
REQ-033 req_len=16 with BURST_MAX=16 SHALL visit all 16 addresses once.

Reset
REQ-034 Asserting rst SHALL, asynchronously and mid-burst included, force state=IDLE, addr=0, remaining=0, dir=0.
REQ-035 During reset the outputs SHALL be enable=0, busy=0, done=0 and err=0.
REQ-036 req_ready SHALL be 1 from the first edge after rst deasserts; a burst interrupted by reset is discarded, not resumed.

Verification
REQ-037 Increment wrap: start=14, len=4, dir=0, stall=0 -> enable high 4 cycles; addr 14,15,0,1; done pulse on the next cycle.
REQ-038 Decrement wrap: start=1, len=3, dir=1 -> addr 1,0,15; then done; busy high exactly 3 cycles.
REQ-039 Stall: start=5, len=3, stall high on the 2nd RUN cycle for 2 cycles -> enable sequence 1,0,0,1,1; addr 5,6,6,6,7.
REQ-040 Illegal request: req_len=0, then req_len=17 -> err pulse each time; enable never asserts; req_ready stays 1.
REQ-041 Reset mid-burst: start=0, len=16, rst at 5th RUN cycle -> enable=0 and addr=0 immediately; after release, a new start=9, len=1 request yields a single addr=9.
REQ-042 Full sweep: start=0, len=16, dir=0, with req_valid held high throughout -> addr 0..15 once each; second request accepted only after DONE.
